pwm_generator: RTL and testbench
================================

PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 SHALL have parameter PRESCALE, default 13: clk cycles per PWM counter step; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port en_reg_out_7_0  input  8  output enables for channels 7..0.
REQ-005 SHALL have port en_reg_out_15_8  input  8  output enables for channels 15..8.
REQ-006 SHALL have port en_reg_pwm_7_0  input  8  PWM-mode select for channels 7..0.
REQ-007 SHALL have port en_reg_pwm_15_8  input  8  PWM-mode select for channels 15..8.
REQ-008 SHALL have port pwm_duty_cycle  input  8  requested duty, 0x00 = 0 %, 0xFF = 100 %.
REQ-009 SHALL have port out  output  16  registered channel outputs; bit i = channel i.
REQ-010 SHALL have port period_start  output  1  one-clk pulse marking the first cycle of each PWM period.

Function
REQ-011 SHALL keep a prescale counter pre_cnt counting 0..PRESCALE-1; tick = (pre_cnt == PRESCALE-1); on tick pre_cnt returns to 0.
REQ-012 SHALL keep an 8-bit pwm_cnt advancing by 1 on each tick only; 0xFF + 1 wraps to 0x00 with no other side effect.
REQ-013 SHALL define PWM period = 256 * PRESCALE clk cycles.
REQ-014 SHALL hold a shadow register duty_active, loaded from pwm_duty_cycle only on the tick where pwm_cnt wraps 0xFF -> 0x00.
REQ-015 SHALL ignore pwm_duty_cycle changes mid-period; the new value takes effect at the next period boundary, with no glitch or runt pulse.
REQ-016 SHALL compute pwm_raw = 1 if duty_active == 0xFF, else (pwm_cnt < duty_active).
REQ-017 SHALL give high time = duty_active * PRESCALE clks per period for duty < 0xFF, 0 clks for 0x00, and the full period for 0xFF.
REQ-018 SHALL register per channel i: out[i] <= en_out[i] ? (en_pwm[i] ? pwm_raw : 1) : 0, where en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}.
REQ-019 SHALL apply enable and mode changes unshadowed, with exactly 1 clk latency from input change to out.
REQ-020 SHALL assert period_start for exactly one clk, in the cycle after the wrap tick, aligned with pwm_cnt == 0x00 first appearing.
REQ-021 SHALL make out[i] = 0 whenever en_out[i] = 0, regardless of en_pwm[i].
REQ-022 SHALL treat all 16 channels identically, sharing one counter and one duty value; channels SHALL NOT be phase-shifted.

Reset
REQ-023 SHALL, when rst_n = 0 at a clk edge, clear pre_cnt, pwm_cnt, duty_active, out (0x0000) and period_start (0).
REQ-024 SHALL treat reset asserted mid-period as an abort: pwm_cnt restarts at 0 on the first clk with rst_n = 1, and duty_active stays 0 until the first wrap.
REQ-025 SHALL have no asynchronous paths; rst_n is sampled only on the rising edge of clk.

Structure
REQ-026 SHALL take PWM_CNT_WIDTH (8), DEFAULT_PRESCALE (13), and the register address constants 0x00..0x04 shared with the SPI register block from a shared package.
REQ-027 SHALL place pre_cnt, pwm_cnt, tick and the wrap indication in one sub-module, pwm_timebase; duty shadowing and output muxing stay in pwm_generator.
REQ-028 SHALL contain no latches and no combinational path from input to output.

Verification
REQ-029 SHALL verify: PRESCALE=2, duty=0x80, en_out=en_pwm=0x0001 -> out[0] high 256 clks, low 256 clks per 512-clk period; period_start every 512 clks.
REQ-030 SHALL verify: duty 0x00 -> out[0] constantly 0; duty 0xFF -> out[0] constantly 1 over two full periods after the boundary.
REQ-031 SHALL verify: duty changed 0x40 -> 0xC0 at pwm_cnt=0x20 -> current period keeps 0x40 timing, and the next period (after period_start) shows 0xC0 timing.
REQ-032 SHALL verify: en_out=0xFFFF, en_pwm=0x00FF, duty=0x10 -> out[15:8]=0xFF constant and out[7:0] toggling in phase; clearing en_out[3] -> out[3]=0 the next clk.
REQ-033 SHALL verify: rst_n low for 1 clk at pwm_cnt=0x90 -> out=0x0000 and period_start=0 next clk; pwm_cnt restarts at 0 and the first period_start follows 256*PRESCALE clks later.
REQ-034 SHALL verify: PRESCALE=1 -> a tick on every clk and a period of 256 clks, with duty=0x01 giving a 1-clk high pulse.

Source files
------------

// File: rtl/pwm_generator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_generator_pkg                                            |
// | Description : Constants and types shared by the PWM generator and the SPI  |
// |               register block. Holds the counter width, the default         |
// |               prescale, the register map and the duty compare function.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pwm_generator_pkg;

  localparam int PWM_CNT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 13;
  localparam int PRESCALE_WIDTH   = 16;   // holds any PRESCALE in 1..65535
  localparam int NUM_CHANNELS     = 16;

  typedef logic [PWM_CNT_WIDTH-1:0] pwm_cnt_t;

  // Register map shared with the SPI register block.
  typedef enum logic [7:0] {
    ADDR_EN_OUT_7_0  = 8'h00,
    ADDR_EN_OUT_15_8 = 8'h01,
    ADDR_EN_PWM_7_0  = 8'h02,
    ADDR_EN_PWM_15_8 = 8'h03,
    ADDR_PWM_DUTY    = 8'h04
  } reg_addr_e;

  // Full scale duty forces a solid high; otherwise a plain compare gives
  // duty*PRESCALE high clocks per period (zero for duty 0).
  function automatic logic pwm_compare(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == '1) ? 1'b1 : (cnt < duty);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_generator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_generator_if                                             |
// | Description : Register-side bundle of the PWM generator.                   |
// |               master : drives enables, mode selects and duty; sees out.    |
// |               slave  : the PWM generator itself.                           |
// |   en_reg_out_7_0/15_8 [8] : output enables, channels 7..0 / 15..8          |
// |   en_reg_pwm_7_0/15_8 [8] : PWM-mode selects, channels 7..0 / 15..8        |
// |   pwm_duty_cycle      [8] : requested duty, 0x00 = 0 %, 0xFF = 100 %       |
// |   out                [16] : registered channel outputs, bit i = channel i  |
// |   period_start         [1] : one-clk pulse on the first cycle of a period  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pwm_generator_if;
  import pwm_generator_pkg::*;

  logic [7:0]              en_reg_out_7_0;
  logic [7:0]              en_reg_out_15_8;
  logic [7:0]              en_reg_pwm_7_0;
  logic [7:0]              en_reg_pwm_15_8;
  logic [7:0]              pwm_duty_cycle;
  logic [NUM_CHANNELS-1:0] out;
  logic                    period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out, period_start
  );

endinterface
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_timebase                                                 |
// | Description : Prescaler plus 8-bit PWM counter. The prescaler counts       |
// |               0..PRESCALE-1; each terminal count is a tick that advances   |
// |               the PWM counter, which wraps 0xFF -> 0x00.                   |
// |   clk          : system clock, rising edge                                 |
// |   rst_n        : synchronous active-low reset                              |
// |   o_pwm_cnt[8] : current PWM counter value                                 |
// |   o_wrap       : high during the tick on which the counter wraps           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pwm_timebase
  import pwm_generator_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE   // legal 1..65535
) (
  input  wire logic clk,
  input  wire logic rst_n,
  output pwm_cnt_t  o_pwm_cnt,
  output logic      o_wrap
);

  localparam logic [PRESCALE_WIDTH-1:0] c_PRE_LAST = PRESCALE_WIDTH'(PRESCALE - 1);

  logic [PRESCALE_WIDTH-1:0] r_pre_cnt;
  pwm_cnt_t                  r_pwm_cnt;
  logic                      w_tick;

  // With PRESCALE = 1 the prescaler stays at 0 and every clock is a tick.
  assign w_tick = (r_pre_cnt == c_PRE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  assign o_pwm_cnt = r_pwm_cnt;
  assign o_wrap    = w_tick && (r_pwm_cnt == '1);

endmodule
`default_nettype wire

// File: rtl/pwm_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_generator                                                |
// | Description : 16-channel PWM generator. One shared timebase and one        |
// |               shadowed duty value drive all channels in phase. Each        |
// |               channel is off, static high, or PWM, per its enable bits.    |
// |   clk   : system clock, rising edge                                        |
// |   rst_n : synchronous active-low reset                                     |
// |   bus   : pwm_generator_if.slave (enables, modes, duty in; out,            |
// |           period_start out, both registered)                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pwm_generator
  import pwm_generator_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE   // clk cycles per counter step
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  pwm_generator_if.slave  bus
);

  pwm_cnt_t                w_pwm_cnt;
  logic                    w_wrap;
  logic                    w_pwm_raw;
  logic [NUM_CHANNELS-1:0] w_en_out;
  logic [NUM_CHANNELS-1:0] w_en_pwm;
  logic [NUM_CHANNELS-1:0] w_out_next;

  pwm_cnt_t                r_duty_active;
  logic [NUM_CHANNELS-1:0] r_out;
  logic                    r_period_start;

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk       (clk),
    .rst_n     (rst_n),
    .o_pwm_cnt (w_pwm_cnt),
    .o_wrap    (w_wrap)
  );

  assign w_en_out  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign w_en_pwm  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  assign w_pwm_raw = pwm_compare(w_pwm_cnt, r_duty_active);

  // Disabled -> 0; enabled static -> 1; enabled PWM -> shared waveform.
  assign w_out_next = w_en_out & (~w_en_pwm | {NUM_CHANNELS{w_pwm_raw}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_duty_active  <= '0;
      r_out          <= '0;
      r_period_start <= 1'b0;
    end else begin
      // Duty is only taken on the wrap, so a period never mixes two values.
      if (w_wrap) begin
        r_duty_active <= bus.pwm_duty_cycle;
      end
      r_out          <= w_out_next;
      // Delayed by one so the pulse lines up with pwm_cnt == 0x00.
      r_period_start <= w_wrap;
    end
  end

  assign bus.out          = r_out;
  assign bus.period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_pwm_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pwm_generator                                             |
// | Description : Directed self-checking bench. dut2 runs PRESCALE = 2         |
// |               (512-clk period), dut1 runs PRESCALE = 1 (256-clk period).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pwm_generator;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  pwm_generator_if bus2();
  pwm_generator_if bus1();

  pwm_generator #(.PRESCALE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  pwm_generator #(.PRESCALE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set2(input logic [15:0] en_out, input logic [15:0] en_pwm, input logic [7:0] duty);
    bus2.en_reg_out_7_0  = en_out[7:0];
    bus2.en_reg_out_15_8 = en_out[15:8];
    bus2.en_reg_pwm_7_0  = en_pwm[7:0];
    bus2.en_reg_pwm_15_8 = en_pwm[15:8];
    bus2.pwm_duty_cycle  = duty;
  endtask

  // Advance until dut2 pulses period_start or the bound runs out.
  task automatic wait_ps2(input int bound, output int cycles, output int hi0);
    cycles = 0;
    hi0    = 0;
    do begin
      step();
      cycles++;
      if (bus2.out[0]) hi0++;
    end while (!bus2.period_start && cycles < bound);
  endtask

  // Run n clocks on dut2 and tally what the outputs did.
  task automatic run_win(input int n, output int hi0, output int ps,
                         output int lo_ff, output int lo_00, output int up_ff);
    hi0 = 0; ps = 0; lo_ff = 0; lo_00 = 0; up_ff = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus2.out[0])            hi0++;
      if (bus2.period_start)      ps++;
      if (bus2.out[7:0]  == 8'hFF) lo_ff++;
      if (bus2.out[7:0]  == 8'h00) lo_00++;
      if (bus2.out[15:8] == 8'hFF) up_ff++;
    end
  endtask

  initial begin
    int cyc, hi, ps, lff, l00, uff, hi_a;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    set2(16'h0000, 16'h0000, 8'h00);
    bus1.en_reg_out_7_0  = 8'h00;
    bus1.en_reg_out_15_8 = 8'h00;
    bus1.en_reg_pwm_7_0  = 8'h00;
    bus1.en_reg_pwm_15_8 = 8'h00;
    bus1.pwm_duty_cycle  = 8'h00;

    // Reset state
    repeat (3) step();
    check("rst_out2", 32'(bus2.out), 32'h0);
    check("rst_ps2",  32'(bus2.period_start), 32'h0);
    check("rst_out1", 32'(bus1.out), 32'h0);
    check("rst_ps1",  32'(bus1.period_start), 32'h0);

    // Duty 0x80 on channel 0; first period after reset runs with duty 0
    set2(16'h0001, 16'h0001, 8'h80);
    bus1.en_reg_out_7_0 = 8'h01;
    bus1.en_reg_pwm_7_0 = 8'h01;
    bus1.pwm_duty_cycle = 8'h01;
    rst_n = 1'b1;
    wait_ps2(600, cyc, hi);
    check("first_ps_delay", 32'(cyc), 32'd512);
    check("first_period_hi", 32'(hi), 32'd0);

    run_win(512, hi, ps, lff, l00, uff);
    check("d80_hi", 32'(hi), 32'd256);
    check("d80_ps_count", 32'(ps), 32'd1);
    check("d80_ps_at_512", 32'(bus2.period_start), 32'h1);

    // Duty 0x00 requested mid-stream: current period keeps 0x80
    set2(16'h0001, 16'h0001, 8'h00);
    run_win(512, hi, ps, lff, l00, uff);
    check("d00_shadow_hi", 32'(hi), 32'd256);
    set2(16'h0001, 16'h0001, 8'hFF);
    run_win(512, hi, ps, lff, l00, uff);
    check("d00_hi", 32'(hi), 32'd0);
    check("d00_ps", 32'(ps), 32'd1);
    run_win(512, hi, ps, lff, l00, uff);
    check("dff_hi_p1", 32'(hi), 32'd512);
    set2(16'h0001, 16'h0001, 8'h40);
    run_win(512, hi, ps, lff, l00, uff);
    check("dff_hi_p2", 32'(hi), 32'd512);

    // Duty 0x40 period; change to 0xC0 at pwm_cnt = 0x20
    run_win(64, hi_a, ps, lff, l00, uff);
    set2(16'h0001, 16'h0001, 8'hC0);
    run_win(448, hi, ps, lff, l00, uff);
    check("d40_hi_kept", 32'(hi_a + hi), 32'd128);
    check("d40_ps", 32'(ps), 32'd1);

    // 0xC0 period; simultaneously all channels enabled, upper byte static
    set2(16'hFFFF, 16'h00FF, 8'h10);
    run_win(512, hi, ps, lff, l00, uff);
    check("dc0_hi", 32'(hi), 32'd384);
    check("dc0_upper_static", 32'(uff), 32'd512);

    // Duty 0x10: lower byte toggles together, upper byte stays high
    run_win(512, hi, ps, lff, l00, uff);
    check("d10_hi", 32'(hi), 32'd32);
    check("d10_lo_all_high", 32'(lff), 32'd32);
    check("d10_lo_all_low", 32'(l00), 32'd480);
    check("d10_upper_static", 32'(uff), 32'd512);

    // Enable change latency
    step();
    step();
    check("en_before", 32'(bus2.out), 32'h0000FFFF);
    set2(16'hFFF7, 16'h00FF, 8'h10);
    check("en_no_comb_path", 32'(bus2.out), 32'h0000FFFF);
    step();
    check("en3_cleared", 32'(bus2.out), 32'h0000FFF7);
    set2(16'h0000, 16'hFFFF, 8'h10);
    step();
    check("en_out_zero", 32'(bus2.out), 32'h0);

    // Reset mid-period at pwm_cnt = 0x90
    set2(16'hFFFF, 16'h0000, 8'h10);
    wait_ps2(600, cyc, hi);
    repeat (288) step();
    check("pre_rst_out", 32'(bus2.out), 32'h0000FFFF);
    rst_n = 1'b0;
    step();
    check("mid_rst_out", 32'(bus2.out), 32'h0);
    check("mid_rst_ps", 32'(bus2.period_start), 32'h0);
    set2(16'h0001, 16'h0001, 8'hFF);
    rst_n = 1'b1;
    wait_ps2(600, cyc, hi);
    check("rst_restart_delay", 32'(cyc), 32'd512);
    check("rst_duty_zero", 32'(hi), 32'd0);
    run_win(512, hi, ps, lff, l00, uff);
    check("rst_then_dff_hi", 32'(hi), 32'd512);

    // PRESCALE = 1, duty 0x01: one-clock pulse per 256-clock period
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus1.period_start && cyc < 300);
    check("p1_found_ps", 32'(bus1.period_start), 32'h1);
    step();
    check("p1_pulse_high", 32'(bus1.out[0]), 32'h1);
    step();
    check("p1_pulse_low", 32'(bus1.out[0]), 32'h0);
    hi = 0;
    ps = 0;
    for (int i = 0; i < 254; i++) begin
      step();
      if (bus1.out[0])       hi++;
      if (bus1.period_start) ps++;
    end
    check("p1_rest_low", 32'(hi), 32'd0);
    check("p1_ps_count", 32'(ps), 32'd1);
    check("p1_ps_at_256", 32'(bus1.period_start), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
